// File: rtl/pirdsp_frac_accumulator.sv
// pirdsp_frac_accumulator: accumulates multiplier products per group, as one full-width word or two independent half-width lanes
module pirdsp_frac_accumulator #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      C_in,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sign,
  input  logic             HALF_1,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic [1:0]       out_ovf,
  output logic [CNT_W-1:0] out_count,
  output logic             mode_err
);
  localparam int L = ACC_W / 2;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_n;
  logic mode_q, sign_q, first, mode_e, sign_e, f_ov, fs;
  logic [ACC_W-1:0] acc_q, acc_n, ext_f, ext, full_r;
  logic [ACC_W:0] f_sum;
  logic [1:0][L-1:0] ext_l, lane_r;
  logic [1:0] lane_ov, ovf_q, ovf_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  assign first = state == IDLE;
  assign mode_e = first ? HALF_1 : mode_q;
  assign sign_e = first ? in_sign : sign_q;
  assign ext_f = {{(ACC_W-16){sign_e & C_in[15]}}, C_in};
  assign ext = mode_e ? ext_l : ext_f;
  assign f_sum = {1'b0, acc_q} + {1'b0, ext_f};
  assign fs = acc_q[ACC_W-1];
  assign f_ov = sign_q ? (fs == ext_f[ACC_W-1] && f_sum[ACC_W-1] != fs) : f_sum[ACC_W];
  assign full_r = (f_ov && SATURATE != 0) ? (sign_q ? {fs, {(ACC_W-1){~fs}}} : {ACC_W{1'b1}}) : f_sum[ACC_W-1:0];
  // lanes are summed separately so no carry can leak from lane0 into lane1
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [L:0] ls;
    logic s;
    assign ext_l[g] = {{(L-8){sign_e & C_in[8*g+7]}}, C_in[8*g+:8]};
    assign ls = {1'b0, acc_q[L*g+:L]} + {1'b0, ext_l[g]};
    assign s = acc_q[L*g+L-1];
    assign lane_ov[g] = sign_q ? (s == ext_l[g][L-1] && ls[L-1] != s) : ls[L];
    assign lane_r[g] = (lane_ov[g] && SATURATE != 0) ? (sign_q ? {s, {(L-1){~s}}} : {L{1'b1}}) : ls[L-1:0];
  end
  always_comb begin
    state_n = state;
    acc_n = acc_q;
    cnt_n = cnt_q;
    ovf_n = ovf_q;
    if (in_valid) begin
      state_n = in_last ? IDLE : ACCUM;
      acc_n = first ? ext : mode_q ? lane_r : full_r;
      cnt_n = first ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + 1'b1;
      ovf_n = first ? 2'b00 : ovf_q | (mode_q ? lane_ov : {1'b0, f_ov});
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mode_q <= 1'b0;
      sign_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= '0;
      acc_out <= '0;
      out_valid <= 1'b0;
      out_ovf <= '0;
      out_count <= '0;
      mode_err <= 1'b0;
    end else begin
      state <= state_n;
      acc_q <= acc_n;
      cnt_q <= cnt_n;
      ovf_q <= ovf_n;
      if (first && in_valid) {mode_q, sign_q} <= {HALF_1, in_sign};
      out_valid <= in_valid && in_last;
      mode_err <= in_valid && !first && HALF_1 != mode_q;
      if (in_valid && in_last) begin
        acc_out <= acc_n;
        out_ovf <= ovf_n;
        out_count <= cnt_n;
      end
    end
  end
endmodule

// File: tb/tb_pirdsp_frac_accumulator.sv
// tb_pirdsp_frac_accumulator: random and directed groups against an arithmetic reference model, saturating and wrapping DUTs side by side
module tb_pirdsp_frac_accumulator;
  localparam int AW = 20;
  localparam int CW = 4;
  localparam int L = AW / 2;
  typedef struct {
    logic [AW-1:0] acc;
    logic [1:0] ovf;
    logic [CW-1:0] cnt;
    int due;
  } exp_t;
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0, in_sign = 0, HALF_1 = 0;
  logic [15:0] C_in = '0;
  logic [AW-1:0] a_acc, b_acc;
  logic a_valid, b_valid, a_merr, b_merr;
  logic [1:0] a_ovf, b_ovf;
  logic [CW-1:0] a_cnt, b_cnt;
  int total = 0, bad = 0, cyc = 0;
  exp_t qa[$], qb[$];
  int qma[$], qmb[$];
  longint v[2][2];
  bit o[2][2];
  bit m_mode, m_sign, active = 0;
  int m_cnt;

  pirdsp_frac_accumulator #(.ACC_W(AW), .CNT_W(CW), .SATURATE(1)) dut_a (
    .clk(clk), .reset(reset), .C_in(C_in), .in_valid(in_valid), .in_last(in_last),
    .in_sign(in_sign), .HALF_1(HALF_1), .acc_out(a_acc), .out_valid(a_valid),
    .out_ovf(a_ovf), .out_count(a_cnt), .mode_err(a_merr));
  pirdsp_frac_accumulator #(.ACC_W(AW), .CNT_W(CW), .SATURATE(0)) dut_b (
    .clk(clk), .reset(reset), .C_in(C_in), .in_valid(in_valid), .in_last(in_last),
    .in_sign(in_sign), .HALF_1(HALF_1), .acc_out(b_acc), .out_valid(b_valid),
    .out_ovf(b_ovf), .out_count(b_cnt), .mode_err(b_merr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, longint act, longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", n, act, want, cyc);
    end
  endfunction

  function automatic void cmp_res(string p, exp_t e, logic [AW-1:0] acc, logic [1:0] ovf, logic [CW-1:0] cnt);
    chk({p, "_acc"}, acc, e.acc);
    chk({p, "_ovf"}, ovf, e.ovf);
    chk({p, "_cnt"}, cnt, e.cnt);
    chk({p, "_latency"}, cyc, e.due);
  endfunction

  // monitor: consumes expectations only when the DUTs strobe
  always @(negedge clk) begin
    if (a_valid) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
      else cmp_res("a", qa.pop_front(), a_acc, a_ovf, a_cnt);
    end
    if (b_valid) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
      else cmp_res("b", qb.pop_front(), b_acc, b_ovf, b_cnt);
    end
    if (a_merr) begin
      if (qma.size() == 0) chk("a_unexpected_merr", 1, 0);
      else chk("a_merr_cycle", cyc, qma.pop_front());
    end
    if (b_merr) begin
      if (qmb.size() == 0) chk("b_unexpected_merr", 1, 0);
      else chk("b_merr_cycle", cyc, qmb.pop_front());
    end
  end

  function automatic longint extv(logic [15:0] c, int lane, bit half, bit s);
    logic [7:0] b;
    if (!half) return s ? longint'($signed(c)) : longint'(c);
    b = c[8*lane+:8];
    return s ? longint'($signed(b)) : longint'(b);
  endfunction

  // exact sum, then range check; clamp or reduce modulo 2^w
  function automatic void addv(input longint a, input longint b, input int w, input bit s,
                               input bit sat, output longint r, output bit ov);
    longint m, lo, hi, t, u;
    m = longint'(1) << w;
    lo = s ? -(m / 2) : 0;
    hi = s ? m / 2 - 1 : m - 1;
    t = a + b;
    ov = t < lo || t > hi;
    u = ((t % m) + m) % m;
    if (s && u > hi) u -= m;
    r = !ov ? t : sat ? (t < lo ? lo : hi) : u;
  endfunction

  task automatic beat(bit vld, bit lst, bit h, bit s, logic [15:0] c);
    longint r;
    bit ov;
    exp_t e;
    @(negedge clk);
    in_valid = vld; in_last = lst; HALF_1 = h; in_sign = s; C_in = c;
    if (vld) begin
      if (!active) begin
        m_mode = h; m_sign = s; m_cnt = 1;
        for (int k = 0; k < 2; k++)
          for (int l = 0; l < 2; l++) begin
            v[k][l] = extv(c, l, h, s);
            o[k][l] = 0;
          end
      end else begin
        if (h != m_mode) begin
          qma.push_back(cyc + 1);
          qmb.push_back(cyc + 1);
        end
        m_cnt++;
        for (int k = 0; k < 2; k++)
          for (int l = 0; l < 2; l++) begin
            addv(v[k][l], extv(c, l, m_mode, m_sign), m_mode ? L : AW, m_sign, k == 0, r, ov);
            v[k][l] = r;
            o[k][l] |= ov;
          end
      end
      active = !lst;
      if (lst)
        for (int k = 0; k < 2; k++) begin
          e.acc = m_mode ? {v[k][1][L-1:0], v[k][0][L-1:0]} : v[k][0][AW-1:0];
          e.ovf = m_mode ? {o[k][1], o[k][0]} : {1'b0, o[k][0]};
          e.cnt = CW'(m_cnt > (1 << CW) - 1 ? (1 << CW) - 1 : m_cnt);
          e.due = cyc + 1;
          if (k == 0) qa.push_back(e);
          else qb.push_back(e);
        end
    end
  endtask

  task automatic group(int n, bit h, bit s, logic [15:0] c);
    for (int i = 0; i < n; i++) beat(1, i == n - 1, h, s, c);
  endtask

  task automatic do_reset(bit vld);
    @(negedge clk);
    reset = 1; in_valid = vld; in_last = 0; C_in = 16'h1234;
    active = 0;
    @(negedge clk);
    chk("rst_a_acc", a_acc, 0); chk("rst_a_valid", a_valid, 0);
    chk("rst_a_ovf", a_ovf, 0); chk("rst_a_cnt", a_cnt, 0); chk("rst_a_merr", a_merr, 0);
    chk("rst_b_acc", b_acc, 0); chk("rst_b_valid", b_valid, 0);
    chk("rst_b_ovf", b_ovf, 0); chk("rst_b_cnt", b_cnt, 0); chk("rst_b_merr", b_merr, 0);
    reset = 0; in_valid = 0;
  endtask

  initial begin
    logic [15:0] c;
    int n;
    bit h, s;
    do_reset(0);
    group(3, 0, 1, 16'h0064);
    group(2, 1, 1, 16'h05FD);
    group(9, 1, 1, 16'h4040);
    group(1, 0, 0, 16'hFFFF);
    group(2, 0, 0, 16'h0001);
    beat(0, 0, 0, 0, 0);
    beat(1, 0, 0, 1, 16'h0010);
    do_reset(1);
    beat(1, 0, 0, 1, 16'h0002);
    beat(1, 1, 0, 1, 16'h0003);
    beat(1, 0, 0, 0, 16'h0100);
    beat(1, 1, 1, 0, 16'h0100);
    group(20, 0, 0, 16'h0001);
    group(17, 0, 1, 16'h8000);
    group(20, 0, 0, 16'hFFFF);
    group(20, 1, 1, 16'h8080);
    group(20, 1, 0, 16'hFFFF);
    beat(1, 0, 1, 1, 16'h7F80);
    beat(0, 1, 0, 0, 16'hFFFF);
    beat(0, 0, 1, 1, 16'h1111);
    beat(1, 1, 1, 1, 16'h7F80);
    for (int g = 0; g < 60; g++) begin
      n = $urandom_range(1, 20);
      h = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        c = ($urandom_range(0, 3) == 0) ? 16'h7F7F ^ 16'($urandom_range(0, 1) * 16'hFFFF) : 16'($urandom);
        if ($urandom_range(0, 5) == 0) beat(0, 1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 16'($urandom));
        beat(1, i == n - 1, ($urandom_range(0, 7) == 0) ? ~h : h, ($urandom_range(0, 7) == 0) ? ~s : s, c);
      end
    end
    repeat (4) beat(0, 0, 0, 0, 0);
    chk("a_results_pending", qa.size(), 0);
    chk("b_results_pending", qb.size(), 0);
    chk("a_merr_pending", qma.size(), 0);
    chk("b_merr_pending", qmb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
